// File: rtl/stream_route_ctrl.sv
// Sequencing controller for the password-checker byte-stream demux: steers the
// password head to the checker, then forwards or drains the payload per verdict.
module stream_route_ctrl #(
  parameter int PW_LEN = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             sel,
  output logic             pw_valid,
  input  logic             pw_ready,
  output logic [7:0]       pw_data,
  output logic             pw_last,
  input  logic             check_done,
  input  logic             check_ok,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic [7:0]       pl_data,
  output logic             pl_last,
  output logic             accept,
  output logic             reject,
  output logic             short_err,
  output logic [CNT_W-1:0] pl_count,
  output logic             busy
);
  typedef enum logic [1:0] {S_PW, S_WAIT, S_FWD, S_DRAIN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PW_LEN - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic             short_f, nopl;
  logic [CNT_W-1:0] pcnt, pcnt_inc;
  logic             pw_fin;

  assign pw_fin   = (cnt == LAST_IDX) || in_last;
  assign pcnt_inc = (&pcnt) ? pcnt : pcnt + 1'b1;
  assign busy     = (state != S_PW) || (cnt != 8'd0);

  // Branch steering is purely combinational; outputs are held quiet while in reset.
  always_comb begin
    in_ready = 1'b0;
    pw_valid = 1'b0;
    pw_data  = 8'h00;
    pw_last  = 1'b0;
    pl_valid = 1'b0;
    pl_data  = 8'h00;
    pl_last  = 1'b0;
    if (rst_n) begin
      case (state)
        S_PW: begin
          pw_valid = in_valid;
          in_ready = pw_ready;
          pw_data  = in_data;
          pw_last  = pw_fin;
        end
        S_FWD: begin
          pl_valid = in_valid;
          in_ready = pl_ready;
          pl_data  = in_data;
          pl_last  = in_last;
        end
        S_DRAIN: in_ready = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PW;
      cnt       <= 8'd0;
      sel       <= 1'b0;
      short_f   <= 1'b0;
      nopl      <= 1'b0;
      pcnt      <= '0;
      pl_count  <= '0;
      accept    <= 1'b0;
      reject    <= 1'b0;
      short_err <= 1'b0;
    end else begin
      accept    <= 1'b0;
      reject    <= 1'b0;
      short_err <= 1'b0;
      case (state)
        S_PW: if (in_valid && pw_ready) begin
          if (pw_fin) begin
            cnt     <= 8'd0;
            state   <= S_WAIT;
            nopl    <= in_last && (cnt == LAST_IDX);
            short_f <= in_last && (cnt != LAST_IDX);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: if (check_done) begin
          if (short_f) begin
            short_err <= 1'b1;
            reject    <= 1'b1;
            state     <= S_PW;
          end else if (nopl) begin
            accept   <= check_ok;
            reject   <= !check_ok;
            pl_count <= '0;
            state    <= S_PW;
          end else begin
            state <= check_ok ? S_FWD : S_DRAIN;
            sel   <= check_ok;
          end
          pcnt    <= '0;
          short_f <= 1'b0;
          nopl    <= 1'b0;
        end
        S_FWD: if (in_valid && pl_ready) begin
          pcnt <= pcnt_inc;
          if (in_last) begin
            pl_count <= pcnt_inc;
            accept   <= 1'b1;
            sel      <= 1'b0;
            state    <= S_PW;
          end
        end
        S_DRAIN: if (in_valid && in_last) begin
          reject <= 1'b1;
          state  <= S_PW;
        end
        default: state <= S_PW;
      endcase
    end
  end
endmodule

// File: doc/stream_route_ctrl.md
# stream_route_ctrl

Sequencing controller for the byte-stream demux in the password checker. It steers each incoming frame:
- The first PW_LEN bytes go to the password-check channel (sel=0).
- After the checker's verdict, the remaining bytes go to the payload channel (sel=1) on accept, or are drained and discarded on reject.

The block sits between the stream input and the 1-to-2 demux/checker pair. It owns the `sel` line and the valid/ready handshakes on both branches.

## Interface
- PW_LEN, 8: password bytes at the head of every frame (1..255).
- CNT_W, 16: width of the payload byte counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1  input stream handshake.
- in_data  in  8  input byte.
- in_last  in  1  marks final byte of frame.
- sel  out  1  demux select: 0 = password channel, 1 = payload channel.
- pw_valid / pw_ready  out / in  1 / 1  password channel handshake.
- pw_data  out  8  password byte.
- pw_last  out  1  final password byte.
- check_done  in  1  single-cycle verdict strobe from checker.
- check_ok  in  1  verdict, qualified by check_done.
- pl_valid / pl_ready  out / in  1 / 1  payload channel handshake.
- pl_data  out  8  payload byte.
- pl_last  out  1  final payload byte.
- accept / reject / short_err  out  1 each  single-cycle frame-result pulses.
- pl_count  out  CNT_W  payload bytes forwarded in the last accepted frame.
- busy  out  1  frame in progress.

## Operation
- States:
  - PW: password phase, byte counter `cnt` 0..PW_LEN-1.
  - WAIT: awaiting verdict.
  - FWD: forwarding payload.
  - DRAIN: discarding payload.
- Branch wiring:
  - sel is registered: 1 only in FWD, 0 otherwise.
  - Data not selected is driven 8'h00, both channels.
- PW:
  - pw_valid=in_valid; in_ready=pw_ready; pw_data=in_data.
  - pw_last=1 when cnt==PW_LEN-1 or in_last.
  - On handshake: cnt+1.
  - On handshake of the final password byte: cnt←0, go to WAIT.
    - If in_last was also set on that byte, latch `no_payload`.
    - If in_last came before cnt==PW_LEN-1, latch `short`.
- WAIT:
  - in_ready=0; both valids 0.
  - On check_done:
    - short: short_err and reject pulse, go to PW.
    - no_payload: accept pulse if check_ok (else reject), pl_count←0, go to PW.
    - otherwise: go to FWD if check_ok, DRAIN if not. The payload counter clears.
- FWD:
  - pl_valid=in_valid; in_ready=pl_ready; pl_last=in_last.
  - Each handshake increments the counter, saturating at all-ones.
  - On handshake with in_last: pl_count←final count, accept pulse, go to PW.
- DRAIN:
  - in_ready=1; all bytes discarded.
  - On in_valid&&in_last: reject pulse, go to PW.
- check_done outside WAIT is ignored. The checker must strobe at least 1 cycle after the pw_last handshake.
- busy = (state!=PW) || (cnt!=0).
- Reset values (async on rst_n low):
  - state=PW, cnt=0, sel=0, short=0, no_payload=0, pl_count=0.
  - All pulses 0; both valids 0.
  - in_ready follows pw_ready combinationally once released.
- Reset mid-frame aborts the frame with no result pulse. The next byte after release is treated as password byte 0.

## Timing
- Data and valid paths to either branch are combinational: zero-cycle latency, no buffering.
- Ready is combinational back to in_ready.
- Verdict to first payload transfer: check_done at cycle N; FWD and sel=1 at N+1; first pl handshake possible at N+1.
- Result pulses are registered, asserted the cycle after the terminating handshake/strobe, for exactly 1 cycle.
- Back-to-back frames: a new frame's byte 0 may be accepted the cycle after the previous in_last handshake (DRAIN/FWD→PW).
- Backpressure: a stalled branch ready holds in_ready low. No byte is dropped except in DRAIN.

## Test plan
- PW_LEN=8, frame of 8 password bytes + 4 payload bytes, check_ok=1 two cycles after pw_last:
  - pw_last on byte 8; sel rises the cycle after check_done.
  - pl receives the 4 bytes with pl_last on the 4th; accept=1 for one cycle; pl_count=4.
- Same frame, check_ok=0:
  - 4 payload bytes consumed with pl_valid never high; reject pulse after in_last; pl_count unchanged.
- Short frame, in_last on byte 5:
  - pw_last on byte 5; after check_done, short_err and reject pulse together; busy returns 0.
- Exactly 8 bytes with in_last on byte 8, check_ok=1:
  - accept pulse, pl_count=0, sel never rises.
- Random pw_ready/pl_ready stalls at 50% over 100 frames:
  - every byte appears exactly once on the correct branch, in order; unselected data is always 8'h00.
- rst_n asserted in FWD mid-payload:
  - immediate sel=0, no pulse, pl_count=0.
  - The next 8 bytes go to the password channel.
